// File: rtl/alu_issue_if.sv
// Command/result handshake bundle between an upstream issuer, the alu_issue
// sequencer and the ALU datapath it drives.
interface alu_issue_if #(
   parameter int WIDTH = 8
);
   logic             cmd_valid;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic             cmd_ready;

   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] alu_r;

   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_zero;
   logic             res_err;
   logic [7:0]       done_cnt;

   // master: the environment (issuer, ALU datapath, result consumer)
   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, alu_r, res_ready,
      input  cmd_ready, op, a, b, res_valid, res_data, res_zero, res_err, done_cnt
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_r, res_ready,
      output cmd_ready, op, a, b, res_valid, res_data, res_zero, res_err, done_cnt
   );
endinterface

// File: rtl/alu_issue.sv
// Issue sequencer for a combinational ALU: latches one command, holds it for
// EXEC_CYCLES cycles, captures the result and holds it until it is consumed.
module alu_issue #(
   parameter int WIDTH       = 8,
   parameter int EXEC_CYCLES = 1   // legal range 1..15
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_issue_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD  = 4'(EXEC_CYCLES - 1);
   localparam logic [2:0] OP_RESVD  = 3'd7;

   state_t     state;
   logic [3:0] cnt;

   // Every output is a flop, so no input reaches an output combinationally;
   // cmd_ready/res_valid are kept as registered copies of the state decode.
   // NOTE: all state uses non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order within the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: every register, datapath included, is reset asynchronously so
         // an abandoned command leaves no stale operands or result behind.
         state         <= IDLE;
         cnt           <= '0;
         bus.cmd_ready <= 1'b1;
         bus.res_valid <= 1'b0;
         bus.op        <= '0;
         bus.a         <= '0;
         bus.b         <= '0;
         bus.res_data  <= '0;
         bus.res_zero  <= 1'b0;
         bus.res_err   <= 1'b0;
         bus.done_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  bus.op        <= bus.cmd_op;
                  bus.a         <= bus.cmd_a;
                  bus.b         <= bus.cmd_b;
                  cnt           <= CNT_LOAD;
                  state         <= EXEC;
                  bus.cmd_ready <= 1'b0;
               end
            end

            EXEC: begin
               if (cnt == 4'd0) begin
                  // Reserved opcode: the ALU output is meaningless, report 0.
                  if (bus.op == OP_RESVD) begin
                     bus.res_data <= '0;
                     bus.res_zero <= 1'b1;
                     bus.res_err  <= 1'b1;
                  end else begin
                     bus.res_data <= bus.alu_r;
                     bus.res_zero <= (bus.alu_r == '0);
                     bus.res_err  <= 1'b0;
                  end
                  state         <= RESP;
                  bus.res_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            RESP: begin
               // Returning to IDLE costs a cycle in which no command is taken.
               if (bus.res_ready) begin
                  state         <= IDLE;
                  bus.res_valid <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  if (bus.done_cnt != 8'hFF) begin
                     bus.done_cnt <= bus.done_cnt + 8'd1;
                  end
               end
            end

            default: begin
               state         <= IDLE;
               bus.cmd_ready <= 1'b1;
               bus.res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: one instance with EXEC_CYCLES=1 for function,
// backpressure, reset and saturation, one with EXEC_CYCLES=4 for back-to-back timing.
module tb_alu_issue;

   typedef struct {
      logic [7:0] data;
      logic       zero;
      logic       err;
      int         acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst0;
   logic rst1;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   hs0   = 0;
   int   hs1   = 0;

   exp_t q0[$];
   exp_t q1[$];

   logic       prev_v [2];
   logic [7:0] held_d [2];
   logic       held_z [2];
   logic       held_e [2];

   logic rr_mode = 1'b0;
   logic rdy_man = 1'b1;

   alu_issue_if #(.WIDTH(8)) bus0 ();
   alu_issue_if #(.WIDTH(8)) bus1 ();

   alu_issue #(.WIDTH(8), .EXEC_CYCLES(1)) u0 (.clk(clk), .rst_n(rst0), .bus(bus0));
   alu_issue #(.WIDTH(8), .EXEC_CYCLES(4)) u1 (.clk(clk), .rst_n(rst1), .bus(bus1));

   // Reference ALU; opcode 7 drives all-ones so a leak into the result shows.
   function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << 1;
         3'd6:    return ~a;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic exp_t expect_of(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int acc);
      exp_t x;
      x.data = (op == 3'd7) ? 8'h00 : ref_alu(op, a, b);
      x.zero = (x.data == 8'h00);
      x.err  = (op == 3'd7);
      x.acc  = acc;
      return x;
   endfunction

   assign bus0.alu_r = ref_alu(bus0.op, bus0.a, bus0.b);
   assign bus1.alu_r = ref_alu(bus1.op, bus1.a, bus1.b);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst0)
      if (!rst0) hs0 <= 0;
      else if (bus0.res_valid && bus0.res_ready) hs0 <= hs0 + 1;

   always @(posedge clk or negedge rst1)
      if (!rst1) hs1 <= 0;
      else if (bus1.res_valid && bus1.res_ready) hs1 <= hs1 + 1;

   always @(posedge clk) begin
      #1;
      bus0.res_ready = rr_mode ? ($urandom_range(0, 3) != 0) : rdy_man;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   task automatic monitor(input int k, input logic v, input logic [7:0] d, input logic z,
                          input logic e, input logic [7:0] dc, input int hs);
      exp_t x;
      int   lat;
      lat = (k == 0) ? 1 : 4;
      if (v && !prev_v[k]) begin
         if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result[%0d]: got data %0h, expected no result", k, d);
         end else begin
            if (k == 0) x = q0.pop_front();
            else        x = q1.pop_front();
            check($sformatf("res_data[%0d]", k), d, x.data);
            check($sformatf("res_zero[%0d]", k), z, x.zero);
            check($sformatf("res_err[%0d]", k), e, x.err);
            check($sformatf("latency[%0d]", k), cyc - x.acc, lat);
         end
         held_d[k] = d;
         held_z[k] = z;
         held_e[k] = e;
      end else if (v) begin
         check($sformatf("hold_data[%0d]", k), d, held_d[k]);
         check($sformatf("hold_zero[%0d]", k), z, held_z[k]);
         check($sformatf("hold_err[%0d]", k), e, held_e[k]);
      end
      prev_v[k] = v;
      check($sformatf("done_cnt[%0d]", k), dc, (hs > 255) ? 255 : hs);
   endtask

   always @(negedge clk) begin
      if (rst0) monitor(0, bus0.res_valid, bus0.res_data, bus0.res_zero, bus0.res_err, bus0.done_cnt, hs0);
      else      prev_v[0] = 1'b0;
      if (rst1) monitor(1, bus1.res_valid, bus1.res_data, bus1.res_zero, bus1.res_err, bus1.done_cnt, hs1);
      else      prev_v[1] = 1'b0;
   end

   task automatic issue0(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int t;
      t = 0;
      @(negedge clk);
      while (!bus0.cmd_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bus0.cmd_ready) begin
         fail_now("issue0_wait_ready");
         return;
      end
      bus0.cmd_valid = 1'b1;
      bus0.cmd_op    = op;
      bus0.cmd_a     = a;
      bus0.cmd_b     = b;
      q0.push_back(expect_of(op, a, b, cyc + 1));
      @(negedge clk);
      bus0.cmd_valid = 1'b0;
      bus0.cmd_op    = 3'($urandom);
      bus0.cmd_a     = 8'($urandom);
      bus0.cmd_b     = 8'($urandom);
      check("op_captured", bus0.op, op);
      check("a_captured", bus0.a, a);
      check("b_captured", bus0.b, b);
   endtask

   task automatic check_reset0();
      check("rst_cmd_ready", bus0.cmd_ready, 1);
      check("rst_res_valid", bus0.res_valid, 0);
      check("rst_op", bus0.op, 0);
      check("rst_a", bus0.a, 0);
      check("rst_b", bus0.b, 0);
      check("rst_res_data", bus0.res_data, 0);
      check("rst_res_zero", bus0.res_zero, 0);
      check("rst_res_err", bus0.res_err, 0);
      check("rst_done_cnt", bus0.done_cnt, 0);
   endtask

   task automatic drain0();
      int t;
      t = 0;
      while ((q0.size() != 0 || bus0.res_valid) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (q0.size() != 0 || bus0.res_valid) fail_now("drain0");
   endtask

   initial begin
      logic [2:0] lo;
      logic [7:0] la;
      logic [7:0] lb;
      int         acc_cnt;
      int         last;
      int         t;

      prev_v[0] = 1'b0;
      prev_v[1] = 1'b0;
      bus0.cmd_valid = 1'b0; bus0.cmd_op = '0; bus0.cmd_a = '0; bus0.cmd_b = '0;
      bus1.cmd_valid = 1'b0; bus1.cmd_op = '0; bus1.cmd_a = '0; bus1.cmd_b = '0;
      bus1.res_ready = 1'b1;
      rst0 = 1'b1;
      rst1 = 1'b1;
      #1;
      rst0 = 1'b0;
      rst1 = 1'b0;
      #1;
      check_reset0();
      check("rst_cmd_ready_1", bus1.cmd_ready, 1);
      check("rst_res_valid_1", bus1.res_valid, 0);

      // Command is already waiting at release: accepted on the first edge.
      @(negedge clk);
      bus0.cmd_valid = 1'b1;
      bus0.cmd_op    = 3'd1;
      bus0.cmd_a     = 8'h05;
      bus0.cmd_b     = 8'h03;
      rst0 = 1'b1;
      rst1 = 1'b1;
      q0.push_back(expect_of(3'd1, 8'h05, 8'h03, cyc + 1));
      @(negedge clk);
      bus0.cmd_valid = 1'b0;
      check("first_accept_op", bus0.op, 3'd1);
      check("first_accept_a", bus0.a, 8'h05);
      check("first_accept_b", bus0.b, 8'h03);
      drain0();
      @(negedge clk);
      check("done_after_basic", bus0.done_cnt, 1);

      // Backpressure with a zero result while upstream keeps pushing junk.
      rdy_man = 1'b0;
      issue0(3'd1, 8'h09, 8'h09);
      t = 0;
      while (!bus0.res_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!bus0.res_valid) fail_now("bp_wait_valid");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_res_valid", bus0.res_valid, 1);
         check("bp_cmd_ready", bus0.cmd_ready, 0);
         check("bp_op_held", bus0.op, 3'd1);
         check("bp_a_held", bus0.a, 8'h09);
         check("bp_b_held", bus0.b, 8'h09);
         bus0.cmd_valid = 1'b1;
         bus0.cmd_op    = 3'($urandom);
         bus0.cmd_a     = 8'($urandom);
         bus0.cmd_b     = 8'($urandom);
      end
      @(negedge clk);
      bus0.cmd_valid = 1'b0;
      rdy_man = 1'b1;
      drain0();
      @(negedge clk);
      check("done_after_bp", bus0.done_cnt, 2);

      // Reserved opcode: ALU drives all-ones, result must read as zero/error.
      issue0(3'd7, 8'($urandom), 8'($urandom));
      drain0();

      // Asynchronous reset while the command is in EXEC.
      issue0(3'd3, 8'hA5, 8'h0F);
      #2;
      rst0 = 1'b0;
      #1;
      check_reset0();
      q0.delete();
      @(negedge clk);
      rst0 = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_no_valid", bus0.res_valid, 0);
      check("post_rst_done", bus0.done_cnt, 0);

      // Saturation with random ops and random downstream stalls.
      rr_mode = 1'b1;
      for (int i = 0; i < 260; i++) begin
         issue0(3'($urandom), 8'($urandom), 8'($urandom));
      end
      drain0();
      rr_mode = 1'b0;
      rdy_man = 1'b1;
      repeat (2) @(negedge clk);
      check("done_saturated", bus0.done_cnt, 255);
      issue0(3'd0, 8'h10, 8'h20);
      drain0();
      @(negedge clk);
      check("done_holds", bus0.done_cnt, 255);

      // Back-to-back sweep on the EXEC_CYCLES=4 instance.
      acc_cnt = 0;
      last    = 0;
      lo = '0; la = '0; lb = '0;
      for (int c = 0; c < 90 && acc_cnt < 12; c++) begin
         @(negedge clk);
         if (acc_cnt > 0) begin
            check("sweep_op_held", bus1.op, lo);
            check("sweep_a_held", bus1.a, la);
            check("sweep_b_held", bus1.b, lb);
         end
         bus1.cmd_valid = 1'b1;
         if (bus1.cmd_ready) begin
            if (acc_cnt > 0) check("accept_spacing", cyc + 1 - last, 6);
            lo = 3'($urandom);
            la = 8'($urandom);
            lb = 8'($urandom);
            bus1.cmd_op = lo;
            bus1.cmd_a  = la;
            bus1.cmd_b  = lb;
            q1.push_back(expect_of(lo, la, lb, cyc + 1));
            last = cyc + 1;
            acc_cnt++;
         end else begin
            bus1.cmd_op = 3'($urandom);
            bus1.cmd_a  = 8'($urandom);
            bus1.cmd_b  = 8'($urandom);
         end
      end
      @(negedge clk);
      bus1.cmd_valid = 1'b0;
      check("sweep_accepts", acc_cnt, 12);
      t = 0;
      while ((q1.size() != 0 || bus1.res_valid) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (q1.size() != 0 || bus1.res_valid) fail_now("drain1");
      @(negedge clk);
      check("sweep_done_cnt", bus1.done_cnt, 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits.
REQ-002 Parameter: EXEC_CYCLES, default 1, range 1-15, number of cycles OP/A/B are held before the result is sampled.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 CMD_VALID  input  1  upstream command present.
REQ-006 CMD_OP  input  3  ALU opcode 0-6; 7 is reserved.
REQ-007 CMD_A, CMD_B  input  WIDTH  operands.
REQ-008 CMD_READY  output  1  block accepts a command this cycle.
REQ-009 OP  output  3  opcode to the ALU control decoder.
REQ-010 A, B  output  WIDTH  operands to the ALU datapath.
REQ-011 ALU_R  input  WIDTH  combinational ALU result for the current OP/A/B.
REQ-012 RES_VALID  output  1  result available.
REQ-013 RES_READY  input  1  downstream accepts the result.
REQ-014 RES_DATA  output  WIDTH  captured result.
REQ-015 RES_ZERO  output  1  RES_DATA equals 0.
REQ-016 RES_ERR  output  1  the command used reserved opcode 7.
REQ-017 DONE_CNT  output  8  count of completed result handshakes, saturating at 255.

Function
REQ-018 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-019 CMD_READY SHALL be 1 exactly when state is IDLE; it depends on no input.
REQ-020 In IDLE, CMD_VALID=1 SHALL capture CMD_OP/CMD_A/CMD_B into OP/A/B, load the exec counter with EXEC_CYCLES-1, and go to EXEC.
REQ-021 In EXEC, the counter SHALL decrement each cycle. When the counter is 0, the block SHALL capture ALU_R into RES_DATA and go to RESP on that edge.
REQ-022 With opcode 7, the block SHALL still spend EXEC_CYCLES in EXEC, capture RES_DATA=0 (ignoring ALU_R), and set RES_ERR=1. Otherwise RES_ERR=0.
REQ-023 RES_ZERO SHALL be registered together with RES_DATA, and SHALL be 1 when the captured value is 0, including the opcode-7 case.
REQ-024 Latency SHALL be fixed: RES_VALID rises exactly EXEC_CYCLES cycles after the accepting edge.
REQ-025 RES_VALID SHALL be 1 exactly when state is RESP. RES_DATA, RES_ZERO and RES_ERR SHALL stay stable while RES_VALID=1 and RES_READY=0.
REQ-026 In RESP, RES_READY=1 SHALL return the FSM to IDLE on that edge and increment DONE_CNT unless it is already 255.
REQ-027 No command SHALL be accepted in the RESP-to-IDLE cycle. Minimum spacing between accepts is EXEC_CYCLES+2 cycles.
REQ-028 OP, A and B SHALL hold the last captured values in every state, including IDLE and RESP. They change only on an accept.
REQ-029 Changes on CMD_* while not in IDLE SHALL have no effect. ALU_R SHALL be ignored outside the sampling edge.
REQ-030 RES_READY while not in RESP SHALL have no effect.
REQ-031 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-032 RST_N=0 SHALL immediately, without a clock edge, force state=IDLE, OP=0, A=0, B=0, RES_DATA=0, RES_ZERO=0, RES_ERR=0, DONE_CNT=0 and the exec counter to 0. CMD_READY=1 and RES_VALID=0 follow from the state.
REQ-033 Assertion of reset during EXEC or RESP SHALL abandon the command. No result is delivered and DONE_CNT is not incremented.
REQ-034 The first accept after reset release SHALL be possible on the first rising edge with RST_N=1.

Verification
REQ-035 Basic op, EXEC_CYCLES=1: accept OP=1, A=8'h05, B=8'h03, model ALU_R=A-B -> RES_VALID high 1 cycle after accept, RES_DATA=8'h02, RES_ZERO=0, RES_ERR=0, DONE_CNT=1 after handshake.
REQ-036 Backpressure: hold RES_READY=0 for 5 cycles with RES_DATA=8'h00 -> RES_VALID, RES_DATA=0 and RES_ZERO=1 stable for all 5 cycles. CMD_READY=0 throughout. CMD_* changes are ignored.
REQ-037 Reserved op: accept OP=7, ALU_R=8'hFF -> RES_DATA=0, RES_ERR=1, RES_ZERO=1.
REQ-038 Latency sweep: EXEC_CYCLES=4, back-to-back CMD_VALID=1 with RES_READY=1 -> OP/A/B stable 4 cycles, accepts every 6 cycles.
REQ-039 Reset mid-operation: RST_N low asynchronously (between edges) in EXEC -> outputs reach reset values before the next edge, no RES_VALID pulse, DONE_CNT unchanged at 0.
REQ-040 Saturation: complete 260 commands -> DONE_CNT reads 255 and holds.
